mio_responder: RTL and testbench
================================

# mio_responder

Memory-mapped data-side responder for the pipelined RISC-V core: the slave end of the core's MEM-stage bus (address, store data, write strobe, DMType). It holds the data RAM plus a small I/O page (LEDs, switches, interval timer) and performs DMType-driven byte-lane store merging and load extension. Read data is returned in the same cycle, so the core captures it into MEM/WB at the next edge. It also raises the core's interrupt line from the timer.

## Interface
- `RAM_WORDS`, 1024, data RAM depth in 32-bit words; power of two.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `mem_w`  in  1  store strobe from the core's MEM stage.
- `cpu_addr`  in  32  byte address, the core's ALU result.
- `cpu_wdata`  in  32  store data, right-aligned.
- `DMType`  in  3  access size: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; other values are treated as word.
- `cpu_rdata`  out  32  load data, extended and right-aligned; combinational.
- `MIO_ready`  out  1  responder ready.
- `INT`  out  1  interrupt request to the core; level.
- `sw_in`  in  16  switch inputs.
- `led_out`  out  16  LED register.

## Operation
- **Address map:**
  - RAM occupies 0x0000_0000 up to RAM_WORDS*4-1 and is indexed by `cpu_addr[log2(RAM_WORDS)+1:2]`.
  - The I/O page is 0xFFFF_0000 to 0xFFFF_00FF.
  - Any other address is unmapped: reads return 0 and writes are ignored.
- **I/O registers** (selected by `cpu_addr[7:2]`):
  - 0x00 LED (RW, bits [15:0]; upper bits read 0).
  - 0x04 SW (RO, zero-extended `sw_in`).
  - 0x08 TCNT (RO).
  - 0x0C TCMP (RW).
  - 0x10 TCTRL: bit0 EN, bit1 IE, bit2 PEND. PEND is read/write-1-to-clear. Other bits read 0.
  - Unused offsets read 0 and ignore writes.
- **Loads:**
  - The full 32-bit word is selected first.
  - Byte loads take lane `cpu_addr[1:0]`.
  - Halfword loads take lane `cpu_addr[1]` (`cpu_addr[0]` ignored).
  - Word loads ignore `cpu_addr[1:0]`.
  - Signed types sign-extend from bit 7 or 15; unsigned types zero-extend.
  - The same lane rule applies to the I/O page.
- **RAM stores:**
  - Merge at the rising edge when `mem_w`=1.
  - Byte stores write `cpu_wdata[7:0]` to the addressed lane; half stores write `cpu_wdata[15:0]` to lanes {2a+1,2a}; word stores write all lanes.
  - Unwritten lanes are preserved.
- **I/O stores:** only word-type stores take effect; byte and half stores to the I/O page are ignored.
- **Timer:**
  - While EN=1, TCNT increments by 1 each cycle.
  - When TCNT==TCMP with EN=1, the next edge sets TCNT to 0 and sets PEND.
  - Any write to TCMP also clears TCNT to 0.
  - EN=0 freezes TCNT.
- **Interrupt:** `INT` = PEND & IE, taken from registers (glitch-free).
- **Simultaneous events:**
  - A PEND set from a timer match in the same cycle as a write-1-to-clear of PEND: the set wins, and PEND stays 1.
  - A TCMP write in the same cycle as a timer match: the write wins. TCMP takes the new value, TCNT goes to 0, and PEND is not set.
- **MIO_ready:** 0 while in reset, 1 from the first rising edge after `rst` deasserts, and 1 thereafter.

## Timing
- Read path (`cpu_addr`/`DMType` to `cpu_rdata`) has zero cycles of latency.
- Writes land at the rising edge of the cycle where `mem_w`=1. A read of the same address in the following cycle returns the new data.
- A read in the same cycle as a write returns the old data.
- TCNT, PEND and `INT` update one edge after their cause.
- **Reset values:**
  - `cpu_rdata` follows the combinational read of post-reset state.
  - `led_out`=0, LED=0.
  - TCNT=0, TCMP=0xFFFF_FFFF, TCTRL=0.
  - `INT`=0, `MIO_ready`=0.
  - RAM contents are not reset.
- Reset asserted mid-operation immediately forces all registers above to their reset values. A store in flight during that cycle is dropped for the I/O page; RAM contents are undefined for that word.
- TCNT wraps 0xFFFF_FFFF to 0 when no match occurs.

## Test plan
- **Word store then load:** store word 0x8899_AABB at 0x10, then load word at 0x10 → `cpu_rdata`=0x8899_AABB in the cycle after the store.
- **Byte and half lanes:** after the word store above:
  - store byte 0x5A at 0x12 → the word at 0x10 reads 0x885A_AABB.
  - load byte signed at 0x13 → 0xFFFF_FF88.
  - load byte unsigned at 0x13 → 0x0000_0088.
  - load half signed at 0x10 → 0xFFFF_AABB.
- **Timer and interrupt:** write TCMP=3, then TCTRL=0x3 → TCNT counts 0,1,2,3,0. PEND and `INT` go 1 on the edge where TCNT returns to 0. Writing TCTRL=0x7 then clears `INT` next cycle unless a match coincides.
- **Set-wins collision:** with TCMP=0 and EN=1 (a match every cycle), write TCTRL=0x7 → PEND stays 1 and `INT` stays 1.
- **I/O and unmapped accesses:**
  - `sw_in`=0xA5A5, load word at 0xFFFF_0004 → 0x0000_A5A5.
  - Store word 0x1234 to 0xFFFF_0000 → `led_out`=0x1234.
  - Store byte to 0xFFFF_0000 → LED unchanged.
  - Load at 0x8000_0000 → 0.
- **Reset:** assert `rst` low mid-count with `INT`=1 → `INT`, `MIO_ready`, `led_out` and TCNT go to 0 without waiting for a clock edge. `MIO_ready` returns to 1 at the first edge after release.

Source files
------------

// File: rtl/mio_responder.sv
// Data-side bus responder: data RAM, LED/switch I/O page and interval timer.
// Same-cycle load path with DMType lane extraction; lane-merged RAM stores.
module mio_responder #(
  parameter int RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  DMType,
  output logic [31:0] cpu_rdata,
  output logic        MIO_ready,
  output logic        INT,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          ram_sel;
  logic          io_sel;
  logic [5:0]    io_off;

  logic          is_byte;
  logic          is_half;
  logic          sgn;
  logic [3:0]    be;
  logic [31:0]   wdat;

  logic [31:0]   rd_word;
  logic [31:0]   io_rd;
  logic [7:0]    rd_b;
  logic [15:0]   rd_h;

  logic [15:0]   led_q;
  logic [31:0]   tcnt;
  logic [31:0]   tcmp;
  logic          en;
  logic          ie;
  logic          pend;
  logic          int_q;
  logic          ready_q;

  logic [31:0]   tcnt_n;
  logic          pend_n;
  logic          en_n;
  logic          ie_n;
  logic          io_we;
  logic          we_led;
  logic          we_tcmp;
  logic          we_tctrl;
  logic          match;

  assign ram_idx = cpu_addr[AW+1:2];
  assign ram_sel = (cpu_addr[31:AW+2] == '0);
  assign io_sel  = (cpu_addr[31:8] == 24'hFFFF00);
  assign io_off  = cpu_addr[7:2];

  assign is_byte = (DMType == 3'b011) || (DMType == 3'b100);
  assign is_half = (DMType == 3'b001) || (DMType == 3'b010);
  assign sgn     = (DMType == 3'b001) || (DMType == 3'b011);

  always_comb begin
    be   = 4'hF;
    wdat = cpu_wdata;
    unique case (1'b1)
      is_byte: begin
        be   = 4'b0001 << cpu_addr[1:0];
        wdat = {4{cpu_wdata[7:0]}};
      end
      is_half: begin
        be   = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{cpu_wdata[15:0]}};
      end
      default: begin
        be   = 4'hF;
        wdat = cpu_wdata;
      end
    endcase
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_w && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[ram_idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_comb begin
    io_rd = '0;
    case (io_off)
      6'd0:    io_rd = {16'b0, led_q};
      6'd1:    io_rd = {16'b0, sw_in};
      6'd2:    io_rd = tcnt;
      6'd3:    io_rd = tcmp;
      6'd4:    io_rd = {29'b0, pend, ie, en};
      default: io_rd = '0;
    endcase
  end

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      ram_sel: rd_word = ram[ram_idx];
      io_sel:  rd_word = io_rd;
      default: rd_word = '0;
    endcase
  end

  assign rd_b = rd_word[{cpu_addr[1:0], 3'b000} +: 8];
  assign rd_h = cpu_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    cpu_rdata = rd_word;
    unique case (1'b1)
      is_byte: cpu_rdata = {{24{sgn & rd_b[7]}}, rd_b};
      is_half: cpu_rdata = {{16{sgn & rd_h[15]}}, rd_h};
      default: cpu_rdata = rd_word;
    endcase
  end

  assign io_we    = mem_w & io_sel & ~is_byte & ~is_half;
  assign we_led   = io_we & (io_off == 6'd0);
  assign we_tcmp  = io_we & (io_off == 6'd3);
  assign we_tctrl = io_we & (io_off == 6'd4);
  assign match    = en & (tcnt == tcmp);

  // TCMP write beats a match; a match beats the PEND clear.
  always_comb begin
    tcnt_n = tcnt;
    pend_n = pend;
    en_n   = en;
    ie_n   = ie;
    if (we_tcmp)    tcnt_n = '0;
    else if (match) tcnt_n = '0;
    else if (en)    tcnt_n = tcnt + 32'd1;
    if (match && !we_tcmp)           pend_n = 1'b1;
    else if (we_tctrl && cpu_wdata[2]) pend_n = 1'b0;
    if (we_tctrl) begin
      en_n = cpu_wdata[0];
      ie_n = cpu_wdata[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q   <= '0;
      tcnt    <= '0;
      tcmp    <= 32'hFFFF_FFFF;
      en      <= 1'b0;
      ie      <= 1'b0;
      pend    <= 1'b0;
      int_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (we_led)  led_q <= cpu_wdata[15:0];
      if (we_tcmp) tcmp  <= cpu_wdata;
      tcnt    <= tcnt_n;
      en      <= en_n;
      ie      <= ie_n;
      pend    <= pend_n;
      int_q   <= pend_n & ie_n;
      ready_q <= 1'b1;
    end
  end

  assign led_out   = led_q;
  assign INT       = int_q;
  assign MIO_ready = ready_q;

endmodule

// File: tb/tb_mio_responder.sv
// Scoreboard bench for mio_responder: RAM lanes, I/O page, timer, reset.
// Expected load values are queued at stimulus and popped at sample time.
module tb_mio_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [2:0]  DMType = '0;
  logic [15:0] sw_in = '0;
  logic [31:0] cpu_rdata;
  logic        MIO_ready;
  logic        INT;
  logic [15:0] led_out;

  localparam logic [31:0] A_LED = 32'hFFFF_0000;
  localparam logic [31:0] A_SW  = 32'hFFFF_0004;
  localparam logic [31:0] A_CNT = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP = 32'hFFFF_000C;
  localparam logic [31:0] A_CTL = 32'hFFFF_0010;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  mio_responder #(.RAM_WORDS(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_w     (mem_w),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .DMType    (DMType),
    .cpu_rdata (cpu_rdata),
    .MIO_ready (MIO_ready),
    .INT       (INT),
    .sw_in     (sw_in),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] t);
    mem_w     = w;
    cpu_addr  = a;
    cpu_wdata = d;
    DMType    = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t);
    drive(1'b1, a, d, t);
    tick();
    mem_w = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] t,
                      input string n, input logic [31:0] v);
    drive(1'b0, a, 32'h0, t);
    sb.push_back('{n, v});
    #2;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (MIO_ready !== 1'b0 || INT !== 1'b0 || led_out !== 16'h0) begin
      bad++;
      $display("FAIL rst_outs got rdy=%b int=%b led=%h need 0 0 0",
               MIO_ready, INT, led_out);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (MIO_ready !== 1'b0) begin
      bad++;
      $display("FAIL rdy_pre_edge got %b need 0", MIO_ready);
    end
    tick();
    total++;
    if (MIO_ready !== 1'b1) begin
      bad++;
      $display("FAIL rdy_post_edge got %b need 1", MIO_ready);
    end
    load(A_CMP, 3'b000, "rst_tcmp", 32'hFFFF_FFFF);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    load(A_CTL, 3'b000, "rst_tctrl", 32'h0);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    load(A_CNT, 3'b000, "rst_tcnt", 32'h0);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
  endtask

  task automatic test_word_lanes;
    logic [31:0] la [10];
    logic [2:0]  lt [10];
    logic [31:0] lv [10];
    store(32'h10, 32'h1111_1111, 3'b000);
    drive(1'b1, 32'h10, 32'h8899_AABB, 3'b000);
    sb.push_back('{"same_cycle_old", 32'h1111_1111});
    #2;
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    mem_w = 1'b0;
    load(32'h10, 3'b000, "word_after", 32'h8899_AABB);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    store(32'h12, 32'h3C3C_3C5A, 3'b011);
    store(32'h14, 32'h0000_0000, 3'b000);
    store(32'h16, 32'h1234_CAFE, 3'b001);
    store(32'h18, 32'hFFFF_FFFF, 3'b000);
    store(32'h19, 32'h0000_0000, 3'b100);
    la = '{32'h10, 32'h13, 32'h13, 32'h10, 32'h12,
           32'h13, 32'h13, 32'h10, 32'h14, 32'h18};
    lt = '{3'b000, 3'b011, 3'b100, 3'b001, 3'b010,
           3'b001, 3'b111, 3'b011, 3'b000, 3'b000};
    lv = '{32'h885A_AABB, 32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_AABB,
           32'h0000_885A, 32'hFFFF_885A, 32'h885A_AABB, 32'hFFFF_FFBB,
           32'hCAFE_0000, 32'hFFFF_00FF};
    for (int i = 0; i < 10; i++) begin
      load(la[i], lt[i], $sformatf("lane%0d", i), lv[i]);
      e = sb.pop_front();
      total++;
      if (cpu_rdata !== e.v) begin
        bad++;
        $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
      end
      tick();
    end
  endtask

  task automatic test_io;
    sw_in = 16'hA5A5;
    load(A_SW, 3'b000, "sw_read", 32'h0000_A5A5);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    store(A_LED, 32'hFFFF_1234, 3'b000);
    total++;
    if (led_out !== 16'h1234) begin
      bad++;
      $display("FAIL led_word got %h need 1234", led_out);
    end
    store(A_LED, 32'h0000_00FF, 3'b011);
    store(A_LED, 32'h0000_FFFF, 3'b001);
    total++;
    if (led_out !== 16'h1234) begin
      bad++;
      $display("FAIL led_narrow got %h need 1234", led_out);
    end
    store(32'h8000_0010, 32'hDEAD_BEEF, 3'b000);
    load(A_LED, 3'b000, "led_read", 32'h0000_1234);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    load(A_LED + 32'h1, 3'b100, "led_byte1", 32'h0000_0012);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    load(32'h8000_0000, 3'b000, "unmapped", 32'h0);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    load(32'h10, 3'b000, "no_alias", 32'h885A_AABB);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    load(32'hFFFF_0020, 3'b000, "io_unused", 32'h0);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
  endtask

  task automatic test_timer;
    logic [31:0] seq [5];
    seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    store(A_CMP, 32'd3, 3'b000);
    store(A_CTL, 32'h3, 3'b000);
    for (int i = 0; i < 5; i++) begin
      load(A_CNT, 3'b000, $sformatf("tcnt%0d", i), seq[i]);
      e = sb.pop_front();
      total++;
      if (cpu_rdata !== e.v || INT !== (i == 4)) begin
        bad++;
        $display("FAIL %s got cnt=%h int=%b need cnt=%h int=%b",
                 e.nm, cpu_rdata, INT, e.v, (i == 4));
      end
      if (i < 4) tick();
    end
    store(A_CTL, 32'h7, 3'b000);
    total++;
    if (INT !== 1'b0) begin
      bad++;
      $display("FAIL int_clear got %b need 0", INT);
    end
    load(A_CTL, 3'b000, "tctrl_clr", 32'h3);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    store(A_CTL, 32'h0, 3'b000);
    for (int i = 0; i < 2; i++) begin
      load(A_CNT, 3'b000, $sformatf("frozen%0d", i), 32'd3);
      e = sb.pop_front();
      total++;
      if (cpu_rdata !== e.v) begin
        bad++;
        $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
      end
      tick();
    end
  endtask

  task automatic test_collision;
    store(A_CMP, 32'd0, 3'b000);
    store(A_CTL, 32'h3, 3'b000);
    tick();
    total++;
    if (INT !== 1'b1) begin
      bad++;
      $display("FAIL match0_int got %b need 1", INT);
    end
    store(A_CTL, 32'h7, 3'b000);
    total++;
    if (INT !== 1'b1) begin
      bad++;
      $display("FAIL set_wins_int got %b need 1", INT);
    end
    load(A_CTL, 3'b000, "set_wins_ctl", 32'h7);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    store(A_CTL, 32'h2, 3'b000);
    store(A_CTL, 32'h6, 3'b000);
    total++;
    if (INT !== 1'b0) begin
      bad++;
      $display("FAIL idle_clear got %b need 0", INT);
    end
    store(A_CTL, 32'h3, 3'b000);
    store(A_CMP, 32'd5, 3'b000);
    load(A_CTL, 3'b000, "cmp_wins_ctl", 32'h3);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v || INT !== 1'b0) begin
      bad++;
      $display("FAIL %s got %h int=%b need %h int=0",
               e.nm, cpu_rdata, INT, e.v);
    end
    load(A_CMP, 3'b000, "cmp_wins_val", 32'd5);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    load(A_CNT, 3'b000, "cmp_wins_cnt", 32'd0);
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    tick();
    store(A_CTL, 32'h0, 3'b000);
  endtask

  task automatic test_async_reset;
    store(A_LED, 32'h0000_BEEF, 3'b000);
    store(A_CMP, 32'd2, 3'b000);
    store(A_CTL, 32'h3, 3'b000);
    for (int i = 0; i < 20 && INT !== 1'b1; i++) tick();
    total++;
    if (INT !== 1'b1) begin
      bad++;
      $display("FAIL int_wait got %b need 1 within 20 cycles", INT);
    end
    tick();
    drive(1'b0, A_CNT, 32'h0, 3'b000);
    #2;
    rst = 1'b0;
    sb.push_back('{"arst_tcnt", 32'h0});
    #1;
    e = sb.pop_front();
    total++;
    if (cpu_rdata !== e.v) begin
      bad++;
      $display("FAIL %s got %h need %h", e.nm, cpu_rdata, e.v);
    end
    total++;
    if (INT !== 1'b0 || MIO_ready !== 1'b0 || led_out !== 16'h0) begin
      bad++;
      $display("FAIL arst_outs got int=%b rdy=%b led=%h need 0 0 0",
               INT, MIO_ready, led_out);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (MIO_ready !== 1'b0) begin
      bad++;
      $display("FAIL arst_rdy_pre got %b need 0", MIO_ready);
    end
    tick();
    total++;
    if (MIO_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_rdy_post got %b need 1", MIO_ready);
    end
  endtask

  initial begin
    test_reset();
    test_word_lanes();
    test_io();
    test_timer();
    test_collision();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
